// File: rtl/mem_msgs_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mem_msgs_pkg
//  Description : Memory request/response message formats shared by the cache
//                memory responder and its response FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_msgs_pkg;

    localparam int MEM_TYPE_W   = 3;
    localparam int MEM_OPAQUE_W = 8;
    localparam int MEM_ADDR_W   = 32;
    localparam int MEM_LEN_W    = 2;
    localparam int MEM_TEST_W   = 2;
    localparam int MEM_DATA_W   = 32;

    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_READ  = 3'd0;
    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_WRITE = 3'd1;
    localparam logic [MEM_TYPE_W-1:0] MEM_MSG_INIT  = 3'd2;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_ADDR_W-1:0]   addr;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [MEM_TYPE_W-1:0]   msg_type;
        logic [MEM_OPAQUE_W-1:0] opaque;
        logic [MEM_TEST_W-1:0]   test;
        logic [MEM_LEN_W-1:0]    len;
        logic [MEM_DATA_W-1:0]   data;
    } mem_resp_4B_t;

    localparam int MEM_REQ_W  = $bits(mem_req_4B_t);
    localparam int MEM_RESP_W = $bits(mem_resp_4B_t);

    // A len field of zero encodes a full 4-byte access
    function automatic logic [2:0] len_to_nbytes(input logic [MEM_LEN_W-1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_mem_resp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_resp_fifo
//  Description : DEPTH-entry response FIFO with val/rdy dequeue side and
//                circular pointers that wrap at DEPTH-1 (any DEPTH >= 2).
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_resp_fifo
    import mem_msgs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_val,
    input  logic [MEM_RESP_W-1:0] enq_msg,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [MEM_RESP_W-1:0] deq_msg
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_last = c_pw'(DEPTH - 1);

    logic [MEM_RESP_W-1:0] r_entries [DEPTH];
    logic [c_pw-1:0]       r_wptr;
    logic [c_pw-1:0]       r_rptr;
    logic [c_cw-1:0]       r_count;
    logic                  w_pop;

    assign w_pop   = deq_val & deq_rdy;
    assign deq_val = (r_count != '0);
    // Idle output is forced to zero so the message bus is clean after reset
    assign deq_msg = deq_val ? r_entries[r_rptr] : '0;

    // Pointer and occupancy tracking; upstream guarantees no push when full
    // unless a pop happens on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (enq_val) r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            if (w_pop)   r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            case ({enq_val, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are qualified by the count so need no reset
    always_ff @(posedge clk) begin
        if (enq_val) r_entries[r_wptr] <= enq_msg;
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_responder
//  Description : Memory-side responder for the cache refill/evict port. Word
//                storage with byte-lane writes, aligned/masked reads, a fixed
//                LATENCY delay line and an in-order response FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_responder
    import mem_msgs_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memreq_val,
    output logic                  memreq_rdy,
    input  logic [MEM_REQ_W-1:0]  memreq_msg,
    output logic                  memresp_val,
    input  logic                  memresp_rdy,
    output logic [MEM_RESP_W-1:0] memresp_msg
);

    localparam int c_aw = $clog2(NUM_WORDS);
    localparam int c_cw = $clog2(QDEPTH + 1);
    localparam logic [c_cw-1:0] c_qdepth = c_cw'(QDEPTH);

    mem_req_4B_t           w_req;
    mem_resp_4B_t          w_new_resp;
    logic [31:0]           r_mem [NUM_WORDS];
    logic [c_aw-1:0]       w_idx;
    logic [1:0]            w_boff;
    logic [2:0]            w_nbytes;
    int                    w_b;
    int                    w_n;
    logic                  w_is_read;
    logic                  w_is_write;
    logic                  w_accept;
    logic                  w_pop;
    logic [31:0]           w_word;
    logic [31:0]           w_shifted;
    logic [31:0]           w_wr_word;
    logic [31:0]           w_rd_data;
    logic [c_cw-1:0]       r_count;
    logic                  r_pipe_val [LATENCY];
    logic [MEM_RESP_W-1:0] r_pipe_msg [LATENCY];
    logic                  w_unused_addr;

    assign w_req         = memreq_msg;
    assign w_idx         = w_req.addr[c_aw+1:2];
    assign w_unused_addr = ^w_req.addr[31:c_aw+2];
    assign w_boff        = w_req.addr[1:0];
    assign w_nbytes      = len_to_nbytes(w_req.len);
    assign w_b           = int'(w_boff);
    assign w_n           = int'(w_nbytes);
    assign w_is_read     = (w_req.msg_type == MEM_MSG_READ);
    assign w_is_write    = (w_req.msg_type == MEM_MSG_WRITE) || (w_req.msg_type == MEM_MSG_INIT);

    // Ready depends only on the registered count: a same-cycle dequeue does not free a slot
    assign memreq_rdy = !reset && (r_count < c_qdepth);
    assign w_accept   = memreq_val & memreq_rdy;
    assign w_pop      = memresp_val & memresp_rdy;

    // Current word contents are seen before this edge's write commits
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_boff, 3'b000};

    // Byte-lane merge for writes and byte mask for reads; lanes past byte 3 are dropped
    always_comb begin
        w_wr_word = w_word;
        w_rd_data = '0;
        for (int k = 0; k < 4; k++) begin
            if ((k >= w_b) && (k < w_b + w_n)) begin
                w_wr_word[8*k +: 8] = w_req.data[8*(k - w_b) +: 8];
            end
            if (k < w_n) begin
                w_rd_data[8*k +: 8] = w_shifted[8*k +: 8];
            end
        end
    end

    // Response built at accept time; unknown request types return zero data
    always_comb begin
        w_new_resp          = '0;
        w_new_resp.msg_type = w_req.msg_type;
        w_new_resp.opaque   = w_req.opaque;
        w_new_resp.test     = '0;
        w_new_resp.len      = w_req.len;
        w_new_resp.data     = w_is_read ? w_rd_data : 32'd0;
    end

    // Storage write commits on the accept edge; contents survive reset
    always_ff @(posedge clk) begin
        if (w_accept && w_is_write) r_mem[w_idx] <= w_wr_word;
    end

    // Outstanding count covers both the delay line and the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Non-stalling valid delay line; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_pipe_val[i] <= 1'b0;
        end else begin
            r_pipe_val[0] <= w_accept;
            for (int i = 1; i < LATENCY; i++) r_pipe_val[i] <= r_pipe_val[i-1];
        end
    end

    // Message delay line, qualified by the valid bits
    always_ff @(posedge clk) begin
        r_pipe_msg[0] <= w_new_resp;
        for (int i = 1; i < LATENCY; i++) r_pipe_msg[i] <= r_pipe_msg[i-1];
    end

    cache_mem_resp_fifo #(
        .DEPTH (QDEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .enq_val (r_pipe_val[LATENCY-1]),
        .enq_msg (r_pipe_msg[LATENCY-1]),
        .deq_val (memresp_val),
        .deq_rdy (memresp_rdy),
        .deq_msg (memresp_msg)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_responder
//  Description : Directed self-checking bench for cache_mem_responder
//                (NUM_WORDS=256, LATENCY=2, QDEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_mem_responder;
    import mem_msgs_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  memreq_val;
    logic                  memreq_rdy;
    logic [MEM_REQ_W-1:0]  memreq_msg;
    logic                  memresp_val;
    logic                  memresp_rdy;
    logic [MEM_RESP_W-1:0] memresp_msg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(
        .NUM_WORDS (256),
        .LATENCY   (2),
        .QDEPTH    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MEM_REQ_W-1:0] mk(input logic [2:0] t, input logic [7:0] op,
                                                 input logic [31:0] a, input logic [1:0] l,
                                                 input logic [31:0] d);
        return {t, op, a, l, d};
    endfunction

    // Single isolated transaction: checks acceptance, exact latency and all response fields
    task automatic xact(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_data);
        memresp_rdy = 1'b1;
        memreq_msg  = mk(t, op, a, l, d);
        memreq_val  = 1'b1;
        check("x_req_rdy", memreq_rdy, 1);
        step();
        memreq_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("x_early_val", memresp_val, 0);
            step();
        end
        check("x_resp_val", memresp_val, 1);
        check("x_type", memresp_msg[46:44], t);
        check("x_opaque", memresp_msg[43:36], op);
        check("x_test", memresp_msg[35:34], 0);
        check("x_len", memresp_msg[33:32], l);
        check("x_data", memresp_msg[31:0], exp_data);
        step();
        check("x_drained", memresp_val, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int got;
        int got_before;
        logic [MEM_RESP_W-1:0] head;

        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b0;
        step();
        step();
        check("rst_req_rdy", memreq_rdy, 0);
        check("rst_resp_val", memresp_val, 0);
        check("rst_resp_msg", memresp_msg, 0);
        reset = 1'b0;
        #1;
        check("rst_req_rdy_after", memreq_rdy, 1);

        // Write then read, plus sub-word and boundary cases
        xact(MEM_MSG_WRITE, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF, 32'h0);
        xact(MEM_MSG_READ,  8'h02, 32'h10, 2'd0, 32'h0, 32'hDEADBEEF);
        xact(MEM_MSG_WRITE, 8'h03, 32'h20, 2'd0, 32'h11223344, 32'h0);
        xact(MEM_MSG_WRITE, 8'h04, 32'h21, 2'd1, 32'h000000AB, 32'h0);
        xact(MEM_MSG_READ,  8'h05, 32'h20, 2'd0, 32'h0, 32'h1122AB44);
        xact(MEM_MSG_READ,  8'h06, 32'h22, 2'd2, 32'h0, 32'h00001122);
        xact(MEM_MSG_INIT,  8'h07, 32'h04, 2'd0, 32'h55667788, 32'h0);
        xact(MEM_MSG_WRITE, 8'h08, 32'h00, 2'd0, 32'hAABBCCEE, 32'h0);
        xact(MEM_MSG_WRITE, 8'h09, 32'h03, 2'd2, 32'h0000CCDD, 32'h0);
        xact(MEM_MSG_READ,  8'h0A, 32'h00, 2'd0, 32'h0, 32'hDDBBCCEE);
        xact(MEM_MSG_READ,  8'h0B, 32'h04, 2'd0, 32'h0, 32'h55667788);
        xact(MEM_MSG_READ,  8'h0C, 32'h03, 2'd2, 32'h0, 32'h000000DD);
        xact(MEM_MSG_READ,  8'h0D, 32'h01, 2'd3, 32'h0, 32'h00DDBBCC);
        xact(3'd5,          8'h0E, 32'h10, 2'd0, 32'h12345678, 32'h0);
        xact(MEM_MSG_READ,  8'h0F, 32'h10, 2'd0, 32'h0, 32'hDEADBEEF);

        // Back-pressure: only QDEPTH requests accepted while responses are blocked
        memresp_rdy = 1'b0;
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            memreq_val = (sent < 6);
            memreq_msg = mk(MEM_MSG_READ, 8'(sent), 32'h10, 2'd0, 32'h0);
            if (memreq_val && memreq_rdy) sent++;
            step();
        end
        check("bp_accepted", sent, 4);
        check("bp_req_rdy", memreq_rdy, 0);
        check("bp_resp_val", memresp_val, 1);
        head = memresp_msg;
        check("bp_head_opaque", head[43:36], 0);
        step();
        check("bp_hold", memresp_msg, head);

        memresp_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            got_before = got;
            memreq_val = (sent < 6);
            memreq_msg = mk(MEM_MSG_READ, 8'(sent), 32'h10, 2'd0, 32'h0);
            if (memresp_val) begin
                check("bp_opaque", memresp_msg[43:36], 8'(got));
                check("bp_data", memresp_msg[31:0], 32'hDEADBEEF);
                got++;
            end
            if (memreq_val && memreq_rdy) begin
                if (sent == 4) check("bp_accept_after_pop", (got_before >= 1), 1);
                sent++;
            end
            step();
        end
        memreq_val = 1'b0;
        check("bp_all_resp", got, 6);
        check("bp_all_sent", sent, 6);

        // Streaming refill burst: one accept per cycle, responses without bubbles
        memresp_rdy = 1'b1;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 40 && got < 16; c++) begin
            memreq_val = (sent < 16);
            memreq_msg = mk(MEM_MSG_READ, 8'(8'h40 + sent), 32'h20, 2'd0, 32'h0);
            if (memresp_val) begin
                check("st_opaque", memresp_msg[43:36], 8'(8'h40 + got));
                check("st_timing", c, got + 3);
                got++;
            end
            if (memreq_val) begin
                check("st_req_rdy", memreq_rdy, 1);
                if (memreq_rdy) sent++;
            end
            step();
        end
        memreq_val = 1'b0;
        check("st_all_resp", got, 16);

        // Reset with three requests in flight
        memresp_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            memreq_val = 1'b1;
            memreq_msg = mk(MEM_MSG_READ, 8'(8'h60 + c), 32'h10, 2'd0, 32'h0);
            step();
        end
        memreq_val = 1'b0;
        reset = 1'b1;
        step();
        check("mid_rst_resp_val", memresp_val, 0);
        check("mid_rst_resp_msg", memresp_msg, 0);
        check("mid_rst_req_rdy", memreq_rdy, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_req_rdy_after", memreq_rdy, 1);
        for (int c = 0; c < 3; c++) begin
            check("mid_rst_no_ghost", memresp_val, 0);
            step();
        end

        // Count restarted at zero: a full QDEPTH of requests fits again
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            memreq_val = (sent < 4);
            memreq_msg = mk(MEM_MSG_READ, 8'(8'h80 + sent), 32'h10, 2'd0, 32'h0);
            if (memreq_val && memreq_rdy) sent++;
            step();
        end
        memreq_val = 1'b0;
        check("post_rst_accepted", sent, 4);
        memresp_rdy = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (memresp_val) begin
                check("post_rst_opaque", memresp_msg[43:36], 8'(8'h80 + got));
                got++;
            end
            step();
        end
        check("post_rst_all_resp", got, 4);

        xact(MEM_MSG_READ, 8'h70, 32'h10, 2'd0, 32'h0, 32'hDEADBEEF);
        xact(MEM_MSG_READ, 8'h71, 32'h20, 2'd0, 32'h0, 32'h1122AB44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
